// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: turns one multicycle-core load/store into an Avalon-MM
// master access, stalls the core while it is in flight and returns aligned,
// sign/zero-extended load data. Bus accesses that hang are aborted after
// TIMEOUT_CYC cycles with a cpu_err pulse.
module cpu_mem_bridge #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  output logic        stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_DATA, S_DONE, S_ERROR
  } state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_addr, r_wdata, r_rdata;
  logic [1:0]    r_size;
  logic          r_signed, r_is_rd;
  logic [CW-1:0] r_cnt;

  logic          w_req, w_illegal, w_timeout, w_accept;
  logic [31:0]   w_lane, w_ext;

  assign w_req     = cpu_read | cpu_write;
  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC - 1));
  assign w_accept  = (r_state == S_IDLE) & w_req & ~w_illegal;

  // Request legality: conflicting strobes, reserved size, or misalignment.
  always_comb begin
    w_illegal = 1'b0;
    if (cpu_read & cpu_write)                          w_illegal = 1'b1;
    if (cpu_size == 2'b11)                             w_illegal = 1'b1;
    if (cpu_size == 2'b01 && cpu_addr[0])              w_illegal = 1'b1;
    if (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00)   w_illegal = 1'b1;
  end

  // Next state and core/bus handshake outputs. A transfer accepted or data
  // returned in the last allowed cycle still completes rather than aborting.
  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    avm_read  = 1'b0;
    avm_write = 1'b0;
    cpu_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_req & ~w_illegal;
        if (w_req) w_next = w_illegal ? S_ERROR : S_ISSUE;
      end
      S_ISSUE: begin
        stall     = 1'b1;
        avm_read  = r_is_rd;
        avm_write = ~r_is_rd;
        if (!avm_waitrequest) w_next = r_is_rd ? S_WAIT_DATA : S_DONE;
        else if (w_timeout)   w_next = S_ERROR;
      end
      S_WAIT_DATA: begin
        stall = 1'b1;
        if (avm_readdatavalid) w_next = S_DONE;
        else if (w_timeout)    w_next = S_ERROR;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERROR: begin
        cpu_err = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Request capture on acceptance; the bus sees only the latched copy.
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_size   <= 2'b10;
      r_signed <= 1'b0;
      r_is_rd  <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= cpu_addr;
      r_wdata  <= cpu_wdata;
      r_size   <= cpu_size;
      r_signed <= cpu_signed;
      r_is_rd  <= cpu_read;
    end
  end

  // Access watchdog: zeroed as the access starts, runs through ISSUE/WAIT_DATA.
  always_ff @(posedge clk) begin
    if (Rst)                                                r_cnt <= '0;
    else if (w_accept)                                      r_cnt <= '0;
    else if (r_state == S_ISSUE || r_state == S_WAIT_DATA)  r_cnt <= r_cnt + CW'(1);
  end

  // Lane select and extension of returned read data.
  always_comb begin
    w_lane = avm_readdata >> {r_addr[1:0], 3'b000};
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_lane[7]}},  w_lane[7:0]};
      2'b01:   w_ext = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  // Load result; only data arriving while waiting for it is taken.
  always_ff @(posedge clk) begin
    if (Rst)                                             r_rdata <= '0;
    else if (r_state == S_WAIT_DATA && avm_readdatavalid) r_rdata <= w_ext;
  end

  // Lane enables and replicated store data from the latched request.
  always_comb begin
    case (r_size)
      2'b00: begin
        avm_byteenable = 4'b0001 << r_addr[1:0];
        avm_writedata  = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        avm_byteenable = r_addr[1] ? 4'b1100 : 4'b0011;
        avm_writedata  = {2{r_wdata[15:0]}};
      end
      default: begin
        avm_byteenable = 4'b1111;
        avm_writedata  = r_wdata;
      end
    endcase
  end

  assign avm_address = {r_addr[31:2], 2'b00};
  assign cpu_rdata   = r_rdata;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Bench for cpu_mem_bridge: each access is described by its bus timing
// (waitrequest cycles, data latency); the expected per-cycle outputs follow
// from the latency rules, and one negedge process checks every cycle.
module tb_cpu_mem_bridge;
  localparam int TO = 256;

  logic        clk = 1'b0;
  logic        Rst;
  logic        cpu_read, cpu_write, cpu_signed;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_size;
  logic        stall, cpu_err, avm_read, avm_write;
  logic [31:0] cpu_rdata, avm_address, avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;

  cpu_mem_bridge #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .Rst(Rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
    .stall(stall), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  int stall_cnt = 0, err_cnt = 0;
  bit chk_en = 0;
  logic        e_stall = 0, e_rd = 0, e_wr = 0, e_err = 0;
  logic [31:0] e_rdata = 0, e_addr = 0, e_wd = 0;
  logic [3:0]  e_be = 0;
  logic [31:0] last_addr = 0, last_wd = 0;
  logic [3:0]  last_be = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules, expressed arithmetically.
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    return 4'(1 << a);
      2'd1:    return 4'(3 << a);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wd_of(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'd0:    return (wd & 32'hFF) * 32'h01010101;
      2'd1:    return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ext_of(input logic [1:0] sz, input bit sg,
                                         input logic [1:0] a, input logic [31:0] d);
    logic [31:0] lane, v;
    lane = d >> (8 * a);
    case (sz)
      2'd0: begin v = lane & 32'hFF;   if (sg && v >= 128)   v = v - 256;   end
      2'd1: begin v = lane & 32'hFFFF; if (sg && v >= 32768) v = v - 65536; end
      default: v = lane;
    endcase
    return v;
  endfunction

  // Per-cycle comparison against the expected outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", stall, e_stall);
      cmp("avm_read", avm_read, e_rd);
      cmp("avm_write", avm_write, e_wr);
      cmp("cpu_err", cpu_err, e_err);
      cmp("cpu_rdata", cpu_rdata, e_rdata);
      if (e_rd || e_wr) begin
        cmp("avm_address", avm_address, e_addr);
        cmp("avm_byteenable", avm_byteenable, e_be);
        cmp("avm_writedata_or_be", e_wr ? avm_writedata : e_wd, e_wd);
      end
      if (avm_read || avm_write) begin
        last_addr = avm_address; last_be = avm_byteenable; last_wd = avm_writedata;
      end
      if (stall)   stall_cnt++;
      if (cpu_err) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    cpu_size = 0; cpu_signed = 0;
    avm_waitrequest = 0; avm_readdatavalid = 0; avm_readdata = 0;
  endtask

  // One access. W = waitrequest cycles, D = data latency after accept
  // (0 = never), junk = toggle readdatavalid during waitrequest cycles.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input bit sg,
                        input int W, input int D, input logic [31:0] rdat, input bit junk);
    bit legal, abort;
    int acc_c, ev, fin;
    legal = !(rd && wr) && sz != 2'd3 && !(sz == 2'd1 && a[0]) &&
            !(sz == 2'd2 && a[1:0] != 2'd0);
    acc_c = 1 + W;
    ev    = rd ? ((D > 0) ? acc_c + D : (1 << 30)) : acc_c;
    if (!legal)       begin fin = 1;      abort = 1; end
    else if (ev <= TO) begin fin = ev + 1; abort = 0; end
    else              begin fin = TO + 1; abort = 1; end
    stall_cnt = 0; err_cnt = 0;
    for (int c = 0; c <= fin; c++) begin
      step();
      cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
      cpu_size = sz; cpu_signed = sg;
      avm_waitrequest   = (c >= 1 && c <= W);
      avm_readdatavalid = 0;
      avm_readdata      = $urandom;
      if (legal && rd && D > 0 && c == ev) begin
        avm_readdatavalid = 1; avm_readdata = rdat;
      end else if (junk && c >= 1 && c <= W) begin
        avm_readdatavalid = 1;
      end
      e_rd = 0; e_wr = 0; e_err = 0;
      e_addr = {a[31:2], 2'b00}; e_be = be_of(sz, a[1:0]); e_wd = wd_of(sz, wd);
      if (c == 0) e_stall = legal;
      else if (c < fin) begin
        e_stall = 1; e_rd = rd && c <= acc_c; e_wr = wr && c <= acc_c;
      end else begin
        e_stall = 0; e_err = abort;
        if (!abort && rd) e_rdata = ext_of(sz, sg, a[1:0], rdat);
      end
    end
    // Trailing idle cycle with a stray readdatavalid the bridge must ignore.
    step();
    idle_inputs();
    avm_readdatavalid = 1; avm_readdata = 32'hA5A5_5A5A;
    e_stall = 0; e_rd = 0; e_wr = 0; e_err = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    Rst = 1;
    step();
    chk_en = 1;
    e_stall = 0; e_rd = 0; e_wr = 0; e_err = 0; e_rdata = 0;
    step();
    Rst = 0;

    // 1: word store, no waitrequest
    access(0, 1, 32'h100, 32'hDEADBEEF, 2'd2, 0, 0, 0, 0, 0);
    cmp("t1 stall cycles", stall_cnt, 2);
    cmp("t1 be", last_be, 4'b1111);
    cmp("t1 address", last_addr, 32'h100);
    cmp("t1 no err", err_cnt, 0);

    // 2: LB signed/unsigned at 0x203
    access(1, 0, 32'h203, 0, 2'd0, 1, 0, 1, 32'h80123456, 0);
    cmp("t2 signed rdata", cpu_rdata, 32'hFFFFFF80);
    cmp("t2 be", last_be, 4'b1000);
    cmp("t2 stall cycles", stall_cnt, 3);
    access(1, 0, 32'h203, 0, 2'd0, 0, 0, 1, 32'h80123456, 0);
    cmp("t2 unsigned rdata", cpu_rdata, 32'h00000080);

    // 3: half store with 3 waitrequest cycles
    access(0, 1, 32'h6, 32'h0000ABCD, 2'd1, 0, 3, 0, 0, 0);
    cmp("t3 stall cycles", stall_cnt, 5);
    cmp("t3 be", last_be, 4'b1100);
    cmp("t3 writedata", last_wd, 32'hABCDABCD);

    // Byte store lane 1, and signed half load with waits and stray valids
    access(0, 1, 32'h1, 32'h12345678, 2'd0, 0, 1, 0, 0, 0);
    cmp("sb writedata", last_wd, 32'h78787878);
    access(1, 0, 32'h2, 0, 2'd1, 1, 2, 3, 32'h8001_7FFF, 1);
    cmp("lh signed rdata", cpu_rdata, 32'hFFFF8001);

    // 4: illegal requests
    access(1, 0, 32'h102, 0, 2'd2, 0, 0, 1, 32'h1, 0);
    cmp("t4 misaligned err", err_cnt, 1);
    cmp("t4 misaligned stall", stall_cnt, 0);
    access(1, 1, 32'h100, 32'h1, 2'd2, 0, 0, 1, 32'h1, 0);
    cmp("t4 rd+wr err", err_cnt, 1);
    access(0, 1, 32'h0, 32'h1, 2'd3, 0, 0, 0, 0, 0);
    cmp("size11 err", err_cnt, 1);
    access(1, 0, 32'h5, 0, 2'd1, 0, 0, 1, 32'h1, 0);
    cmp("odd half err", err_cnt, 1);

    // 5: load that never returns data
    access(1, 0, 32'h40, 0, 2'd2, 0, 0, 0, 0, 0);
    cmp("t5 timeout err", err_cnt, 1);
    cmp("t5 stall cycles", stall_cnt, TO + 1);
    step();
    avm_readdatavalid = 0;
    cmp("t5 late valid ignored", cpu_rdata, 32'hFFFF8001);

    // 6: reset while waiting for read data
    step();
    cpu_read = 1; cpu_addr = 32'h10; cpu_size = 2'd2;
    e_stall = 1;
    step();
    e_stall = 1; e_rd = 1; e_addr = 32'h10; e_be = 4'hF; e_wd = 0;
    step();
    e_rd = 0; Rst = 1;
    step();
    Rst = 0; idle_inputs();
    avm_readdatavalid = 1; avm_readdata = 32'hFFFF_FFFF;
    e_stall = 0; e_rdata = 0;
    step();
    avm_readdatavalid = 0;
    cmp("t6 rdata after reset", cpu_rdata, 32'h0);
    step();
    cmp("t6 stall idle", stall, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
